// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue bundle for the even/odd issue scoreboard.
// The decode side (master) presents a pair and flush; the scoreboard (slave)
// answers with the issue strobes and pair_ready.
interface issue_scoreboard_if;
  logic        pair_valid;
  logic        pair_ready;
  logic [20:0] ev_src_addr;
  logic [2:0]  ev_src_vld;
  logic [6:0]  ev_dst;
  logic        ev_wr;
  logic [2:0]  ev_lat;
  logic [20:0] od_src_addr;
  logic [2:0]  od_src_vld;
  logic [6:0]  od_dst;
  logic        od_wr;
  logic [2:0]  od_lat;
  logic        issue_even;
  logic        issue_odd;
  logic        flush;

  modport master (
    output pair_valid, ev_src_addr, ev_src_vld, ev_dst, ev_wr, ev_lat,
           od_src_addr, od_src_vld, od_dst, od_wr, od_lat, flush,
    input  pair_ready, issue_even, issue_odd
  );

  modport slave (
    input  pair_valid, ev_src_addr, ev_src_vld, ev_dst, ev_wr, ev_lat,
           od_src_addr, od_src_vld, od_dst, od_wr, od_lat, flush,
    output pair_ready, issue_even, issue_odd
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue scoreboard for the even/odd pipes: tracks in-flight destinations in a
// per-pipe age shift register, holds pairs on RAW hazards, splits a pair when
// the odd half depends on the even half, and kills wrong-path entries on flush.
module issue_scoreboard #(
  parameter int DEPTH = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  issue_scoreboard_if.slave bus,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic       vld;
    logic       wr;
    logic [6:0] dst;
    logic [2:0] lat;
  } entry_t;

  typedef enum logic {
    FULL,
    ODD_ONLY
  } state_t;

  state_t           state_q, state_d;
  entry_t           evTab_q [DEPTH];
  entry_t           odTab_q [DEPTH];
  entry_t           evTab_d [DEPTH];
  entry_t           odTab_d [DEPTH];
  logic [DEPTH-1:0] evBusy, odBusy;
  logic             evHaz, odHaz, intra;
  logic             issueEven, issueOdd, pairReady;
  logic [CNT_W-1:0] stallCnt_q;

  // An entry is still busy until its age reaches its latency; lat 0 never blocks.
  always_comb begin
    evBusy = '0;
    odBusy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      evBusy[k] = evTab_q[k].vld && evTab_q[k].wr && ((k + 1) < int'(evTab_q[k].lat));
      odBusy[k] = odTab_q[k].vld && odTab_q[k].wr && ((k + 1) < int'(odTab_q[k].lat));
    end
  end

  // Compare every valid source against busy entries of both pipes, plus the
  // odd-reads-even dependency inside the pair itself.
  always_comb begin
    evHaz = 1'b0;
    odHaz = 1'b0;
    intra = 1'b0;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (bus.ev_src_vld[s] &&
            ((evBusy[k] && evTab_q[k].dst == bus.ev_src_addr[s*7 +: 7]) ||
             (odBusy[k] && odTab_q[k].dst == bus.ev_src_addr[s*7 +: 7])))
          evHaz = 1'b1;
        if (bus.od_src_vld[s] &&
            ((evBusy[k] && evTab_q[k].dst == bus.od_src_addr[s*7 +: 7]) ||
             (odBusy[k] && odTab_q[k].dst == bus.od_src_addr[s*7 +: 7])))
          odHaz = 1'b1;
      end
      if (bus.ev_wr && bus.od_src_vld[s] && bus.od_src_addr[s*7 +: 7] == bus.ev_dst)
        intra = 1'b1;
    end
  end

  // Issue decision and next state; odd never overtakes even.
  always_comb begin
    state_d   = state_q;
    issueEven = 1'b0;
    issueOdd  = 1'b0;
    pairReady = 1'b0;
    if (!reset && bus.pair_valid) begin
      case (state_q)
        FULL: begin
          if (!evHaz) begin
            issueEven = 1'b1;
            if (!odHaz && !intra) begin
              issueOdd  = 1'b1;
              pairReady = 1'b1;
            end else begin
              state_d = ODD_ONLY;
            end
          end
        end
        ODD_ONLY: begin
          if (!odHaz) begin
            issueOdd  = 1'b1;
            pairReady = 1'b1;
            state_d   = FULL;
          end
        end
        default: state_d = FULL;
      endcase
    end
  end

  assign bus.issue_even = issueEven;
  assign bus.issue_odd  = issueOdd;
  assign bus.pair_ready = pairReady;
  assign stall_cycles   = stallCnt_q;

  // Shift both tables one age step; flush kills the previous pair (now in
  // slot 1) and suppresses this cycle's issue into slot 0.
  always_comb begin
    evTab_d[0] = '{vld: issueEven && !bus.flush, wr: bus.ev_wr, dst: bus.ev_dst, lat: bus.ev_lat};
    odTab_d[0] = '{vld: issueOdd && !bus.flush, wr: bus.od_wr, dst: bus.od_dst, lat: bus.od_lat};
    for (int k = 1; k < DEPTH; k++) begin
      evTab_d[k] = evTab_q[k-1];
      odTab_d[k] = odTab_q[k-1];
    end
    if (bus.flush) begin
      evTab_d[1].vld = 1'b0;
      odTab_d[1].vld = 1'b0;
    end
  end

  // Table registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        evTab_q[k] <= '0;
        odTab_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        evTab_q[k] <= evTab_d[k];
        odTab_q[k] <= odTab_d[k];
      end
    end
  end

  // State register; flush abandons any pending odd half.
  always_ff @(posedge clk) begin
    if (reset)         state_q <= FULL;
    else if (bus.flush) state_q <= FULL;
    else               state_q <= state_d;
  end

  // Saturating count of cycles where a presented pair did not complete.
  always_ff @(posedge clk) begin
    if (reset)
      stallCnt_q <= '0;
    else if (bus.pair_valid && !pairReady && stallCnt_q != {CNT_W{1'b1}})
      stallCnt_q <= stallCnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule
